fetch_stall_ctrl: RTL
=====================

Name: fetch_stall_ctrl

Overview:
- Sequencer for the IF stage and the IF/ID pipeline register.
- Decides each cycle whether the PC advances, whether IF/ID captures, holds or is loaded with a bubble (NOP), and runs the instruction-memory refill handshake on an I-cache miss.
- Combines cache hit/miss, load-use stall from ID, and taken-branch redirect into one prioritised control set.

Parameters:
- ADDR_W, 16, width of PC / memory address.
- CNT_W, 16, width of the saturating miss counter.
- MISS_TIMEOUT, 15, cycles in MISS without mem_ack before a fatal fetch error.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rstn  in  1  synchronous active-low reset.
- pc  in  ADDR_W  current fetch address.
- icache_hit  in  1  I-cache hit for pc this cycle.
- hazard_stall  in  1  load-use hazard detected in ID.
- branch_taken  in  1  redirect resolved this cycle; PC mux already selects the target.
- mem_ack  in  1  refill line delivered by memory (single-cycle pulse).
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID capture enable.
- ifid_flush  out  1  IF/ID loads a bubble; overrides ifid_en.
- mem_req  out  1  refill request, level, held until mem_ack.
- mem_addr  out  ADDR_W  latched miss address.
- cache_fill_we  out  1  I-cache line write strobe.
- fetch_err  out  1  sticky timeout error.
- miss_cnt  out  CNT_W  saturating count of misses.

Behaviour:
- Outputs are combinational decode of state and inputs. IF/ID samples them on negedge, so they must settle within the first half-cycle.
- Reset (rstn=0 at posedge): state=RUN, miss_addr=0, timer=0, miss_cnt=0. Reset also aborts an in-flight refill.
- Output values while rstn=0: pc_en=0, ifid_en=0, ifid_flush=1, mem_req=0, cache_fill_we=0, fetch_err=0.
- States: RUN, MISS, FILL, ERR.
- RUN, priority in order:
  - branch_taken: pc_en=1, ifid_flush=1. No miss entry, because the fetched word is wrong-path.
  - hazard_stall: pc_en=0, ifid_en=0, flush=0. IF/ID holds. No miss entry this cycle.
  - icache_hit: pc_en=1, ifid_en=1.
  - miss: pc_en=0, ifid_flush=1. Next state MISS, miss_addr<=pc, miss_cnt<=miss_cnt+1, saturating at all-ones.
- MISS:
  - mem_req=1, mem_addr=miss_addr, ifid_en=0.
  - ifid_flush = !hazard_stall, so a held ID instruction is never overwritten.
  - pc_en = branch_taken: the redirect is accepted and the refill is still completed; the new pc re-probes in RUN.
  - timer increments each cycle.
  - mem_ack: next FILL, timer<=0.
  - timer==MISS_TIMEOUT-1 with no ack: next ERR. If mem_ack arrives on that same cycle, ack wins.
- FILL (exactly 1 cycle): cache_fill_we=1, pc_en=branch_taken, ifid_en=0, ifid_flush=!hazard_stall. Next RUN.
- ERR: pc_en=0, ifid_en=0, ifid_flush=1, mem_req=0, fetch_err=1. Exit only via reset.
- Latency:
  - Miss in RUN at cycle t: mem_req high from t+1.
  - Ack at cycle a: FILL at a+1, RUN at a+2, where the re-probe hits.
  - Minimum miss penalty is 3 cycles.
- Invariants:
  - ifid_en and ifid_flush are never both 1.
  - mem_req=1 only in MISS.
  - mem_ack outside MISS is ignored.

Decomposition:
- Shared package: state encoding constants (RUN=2'd0, MISS=2'd1, FILL=2'd2, ERR=2'd3) and the NOP/bubble encoding used by IF/ID.
- One sub-module, miss_timer: clear/enable counter with a terminal-count flag at MISS_TIMEOUT-1.

Test Plan:
- Reset then hit=1 for 4 cycles -> pc_en=ifid_en=1 every cycle, flush=0, miss_cnt=0.
- Miss at pc=0x0040, ack 5 cycles later:
  - mem_req high 5 cycles, mem_addr=0x0040.
  - cache_fill_we one cycle, then RUN.
  - miss_cnt=1, IF/ID carries bubbles throughout.
- Miss with hazard_stall=1 during MISS -> ifid_flush=0, ifid_en=0 while stalled. The ID instruction is preserved and the refill still completes.
- branch_taken in MISS:
  - pc_en=1 that cycle, flush=1.
  - Refill completes and RUN re-probes the new pc.
  - Branch with simultaneous miss in RUN -> no MISS entry, miss_cnt unchanged.
- No ack for 15 cycles -> ERR, fetch_err=1, mem_req=0. Stays in ERR for 10 more cycles. rstn=0 clears to RUN.
- Ack on timeout cycle -> FILL, not ERR. Force miss_cnt=0xFFFF and miss again -> stays 0xFFFF.

Source files
------------

// File: rtl/fetch_stall_ctrl_pkg.sv
// fetch_stall_ctrl_pkg: state encoding and IF/ID bubble encoding shared by the fetch sequencer.
package fetch_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1,
        FILL = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_stall_ctrl_miss_timer.sv
// fetch_stall_ctrl_miss_timer: clear/enable counter flagging the last cycle before a refill timeout.
module fetch_stall_ctrl_miss_timer
    import fetch_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk)
        count <= clr ? '0 : en ? count + TW'(1) : count;

    assign tc = en && count == TW'(TIMEOUT - 1);

endmodule

// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl: prioritised PC / IF-ID control and I-cache refill sequencing.
module fetch_stall_ctrl
    import fetch_stall_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int CNT_W        = 16,
    parameter int MISS_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc,
    input  logic              icache_hit,
    input  logic              hazard_stall,
    input  logic              branch_taken,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              cache_fill_we,
    output logic              fetch_err,
    output logic [CNT_W-1:0]  miss_cnt
);

    state_t            state, nxt;
    logic [ADDR_W-1:0] miss_addr;
    logic              tc, miss, run, mis, fil, err;

    assign run  = state == RUN;
    assign mis  = state == MISS;
    assign fil  = state == FILL;
    assign err  = state == ERR;
    assign miss = !branch_taken && !hazard_stall && !icache_hit;

    fetch_stall_ctrl_miss_timer #(.TIMEOUT(MISS_TIMEOUT)) u_timer (
        .clk (clk),
        .clr (!rstn || !mis || mem_ack),
        .en  (mis),
        .tc  (tc)
    );

    always_ff @(posedge clk)
        state <= !rstn ? RUN : nxt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            miss_addr <= '0;
            miss_cnt  <= '0;
        end else if (run && miss) begin
            miss_addr <= pc;
            miss_cnt  <= &miss_cnt ? miss_cnt : miss_cnt + CNT_W'(1);
        end
    end

    // ack on the timeout cycle still completes the refill
    always_comb begin
        nxt = state;
        nxt = run ? (miss ? MISS : RUN) :
              mis ? (mem_ack ? FILL : tc ? ERR : MISS) :
              fil ? RUN : ERR;
    end

    always_comb begin
        pc_en         = rstn && (run ? branch_taken || (!hazard_stall && icache_hit)
                                     : (mis || fil) && branch_taken);
        ifid_en       = rstn && run && !branch_taken && !hazard_stall && icache_hit;
        ifid_flush    = !rstn || (run ? branch_taken || miss : err || !hazard_stall);
        mem_req       = rstn && mis;
        mem_addr      = miss_addr;
        cache_fill_we = rstn && fil;
        fetch_err     = rstn && err;
    end

endmodule
